// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_D    = 2'b01,
        ARB_IF   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          if_stall;
    logic          d_stall;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          bus_err;

    modport slave (
        input  if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ready, d_rdata, d_ready, if_stall, d_stall,
               m_req, m_we, m_addr, m_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, if_stall, d_stall,
               m_req, m_we, m_addr, m_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle counter; tc_o flags the last permitted cycle of an unacknowledged transaction.
module arb_watchdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TMO_W-1:0] count_q;

    // Terminal count is the TMO_CYC-th busy cycle (count starts at zero on the first one).
    assign tc_o = en_i && (count_q == TMO_W'(TMO_CYC - 1));

    // Busy-cycle counter, cleared while the arbiter is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {TMO_W{1'b0}};
        end else if (clr_i) begin
            count_q <= {TMO_W{1'b0}};
        end else if (en_i) begin
            count_q <= count_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one single-ported memory, with stall outputs and watchdog abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255,
    parameter int TMO_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e    state_q;
    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          bus_err_q;
    logic          flushed_q;

    logic          d_req_s;
    logic          ack_s;
    logic          busy_s;
    logic          drop_if_s;
    logic          wd_tc_s;

    assign d_req_s   = bus.d_rd | bus.d_wr;
    assign ack_s     = bus.m_ack & m_req_q;
    assign busy_s    = (state_q == ARB_D) || (state_q == ARB_IF);
    assign drop_if_s = flushed_q | bus.if_flush;

    arb_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ARB_IDLE),
        .en_i  (busy_s && !ack_s),
        .tc_o  (wd_tc_s)
    );

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.if_stall = bus.if_req & ~if_ready_q;
    assign bus.d_stall  = d_req_s & ~d_ready_q;

    // Arbitration FSM with its registered memory-side and pipeline-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= {AW{1'b0}};
            m_wdata_q  <= {DW{1'b0}};
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= {DW{1'b0}};
            d_rdata_q  <= {DW{1'b0}};
            bus_err_q  <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    // Data wins: the older instruction in MEM must not be starved by fetches.
                    if (d_req_s) begin
                        state_q   <= ARB_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_wr;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                    end else if (bus.if_req && !bus.if_flush) begin
                        state_q   <= ARB_IF;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        flushed_q <= 1'b0;
                    end else begin
                        state_q   <= ARB_IDLE;
                    end
                end
                ARB_D: begin
                    if (ack_s || wd_tc_s) begin
                        state_q   <= ARB_IDLE;
                        m_req_q   <= 1'b0;
                        m_we_q    <= 1'b0;
                        d_ready_q <= 1'b1;
                        bus_err_q <= !ack_s;
                        if (!ack_s) begin
                            d_rdata_q <= {DW{1'b0}};
                        end else if (!m_we_q) begin
                            d_rdata_q <= bus.m_rdata;
                        end else begin
                            d_rdata_q <= d_rdata_q;
                        end
                    end else begin
                        state_q <= ARB_D;
                    end
                end
                ARB_IF: begin
                    // A squashed fetch still drains the memory but never reaches the pipeline.
                    if (ack_s || wd_tc_s) begin
                        state_q    <= ARB_IDLE;
                        m_req_q    <= 1'b0;
                        m_we_q     <= 1'b0;
                        if_ready_q <= !drop_if_s;
                        bus_err_q  <= !ack_s;
                        if (!drop_if_s) begin
                            if_rdata_q <= ack_s ? bus.m_rdata : {DW{1'b0}};
                        end else begin
                            if_rdata_q <= if_rdata_q;
                        end
                    end else begin
                        state_q   <= ARB_IF;
                        flushed_q <= drop_if_s;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    m_req_q <= 1'b0;
                    m_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a short watchdog timeout.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TMO_CYC (8),
        .TMO_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;
        repeat (3) cyc();
        chk("rst_m_req",    64'(bus.m_req),    64'h0);
        chk("rst_m_we",     64'(bus.m_we),     64'h0);
        chk("rst_m_addr",   64'(bus.m_addr),   64'h0);
        chk("rst_if_ready", 64'(bus.if_ready), 64'h0);
        chk("rst_d_ready",  64'(bus.d_ready),  64'h0);
        chk("rst_bus_err",  64'(bus.bus_err),  64'h0);
        chk("rst_if_rdata", 64'(bus.if_rdata), 64'h0);
        rst = 1'b1;
        cyc();

        // 1: fetch, ack one cycle after m_req
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        cyc();
        chk("t1_m_req",    64'(bus.m_req),  64'h1);
        chk("t1_m_we",     64'(bus.m_we),   64'h0);
        chk("t1_m_addr",   64'(bus.m_addr), 64'h40);
        chk("t1_if_stall", 64'(bus.if_stall), 64'h1);
        cyc();
        chk("t1_no_early_ready", 64'(bus.if_ready), 64'h0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0010_0093;
        cyc();
        chk("t1_if_ready",  64'(bus.if_ready), 64'h1);
        chk("t1_if_rdata",  64'(bus.if_rdata), 64'h0010_0093);
        chk("t1_m_req_off", 64'(bus.m_req),    64'h0);
        chk("t1_stall_off", 64'(bus.if_stall), 64'h0);
        bus.if_req = 1'b0; bus.m_ack = 1'b0;
        cyc();
        chk("t1_ready_pulse", 64'(bus.if_ready), 64'h0);

        // 2: simultaneous fetch and store, data first
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
        bus.d_wr = 1'b1; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
        cyc();
        chk("t2_m_we",     64'(bus.m_we),     64'h1);
        chk("t2_m_addr",   64'(bus.m_addr),   64'h100);
        chk("t2_m_wdata",  64'(bus.m_wdata),  64'hDEAD_BEEF);
        chk("t2_if_stall", 64'(bus.if_stall), 64'h1);
        chk("t2_d_stall",  64'(bus.d_stall),  64'h1);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h5555_AAAA;
        cyc();
        chk("t2_d_ready",     64'(bus.d_ready),  64'h1);
        chk("t2_store_rdata", 64'(bus.d_rdata),  64'h0);
        chk("t2_d_stall_off", 64'(bus.d_stall),  64'h0);
        chk("t2_if_stall_b",  64'(bus.if_stall), 64'h1);
        bus.d_wr = 1'b0; bus.m_ack = 1'b0;
        cyc();
        chk("t2_if_grant",   64'(bus.m_req),    64'h1);
        chk("t2_if_we",      64'(bus.m_we),     64'h0);
        chk("t2_if_addr",    64'(bus.m_addr),   64'h80);
        chk("t2_if_stall_c", 64'(bus.if_stall), 64'h1);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h1111_1111;
        cyc();
        chk("t2_if_ready", 64'(bus.if_ready), 64'h1);
        chk("t2_if_rdata", 64'(bus.if_rdata), 64'h1111_1111);
        bus.if_req = 1'b0; bus.m_ack = 1'b0;
        cyc();

        // 3: load with 5-cycle wait; address change while busy is ignored
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t3_m_req_%0d", i),   64'(bus.m_req),   64'h1);
            chk($sformatf("t3_m_addr_%0d", i),  64'(bus.m_addr),  64'h200);
            chk($sformatf("t3_d_stall_%0d", i), 64'(bus.d_stall), 64'h1);
            bus.d_addr = 32'h0000_0999;
            if (i == 4) begin
                bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
            end
        end
        cyc();
        chk("t3_d_ready",     64'(bus.d_ready), 64'h1);
        chk("t3_d_rdata",     64'(bus.d_rdata), 64'h1234_5678);
        chk("t3_d_stall_off", 64'(bus.d_stall), 64'h0);
        bus.d_rd = 1'b0; bus.m_ack = 1'b0;
        cyc();
        chk("t3_ready_pulse", 64'(bus.d_ready), 64'h0);

        // 4: flush one cycle after grant
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
        cyc();
        chk("t4_m_req", 64'(bus.m_req), 64'h1);
        bus.if_flush = 1'b1;
        cyc();
        bus.if_flush = 1'b0; bus.if_req = 1'b0;
        bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
        cyc();
        chk("t4_no_ready", 64'(bus.if_ready), 64'h0);
        chk("t4_rdata",    64'(bus.if_rdata), 64'h1111_1111);
        chk("t4_m_req",    64'(bus.m_req),    64'h0);
        bus.m_ack = 1'b0;
        cyc();
        chk("t4_no_ready_b", 64'(bus.if_ready), 64'h0);

        // 4b: flush in idle blocks the grant for that cycle only
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0340; bus.if_flush = 1'b1;
        cyc();
        chk("t4b_blocked", 64'(bus.m_req), 64'h0);
        bus.if_flush = 1'b0;
        cyc();
        chk("t4b_grant", 64'(bus.m_req),  64'h1);
        chk("t4b_addr",  64'(bus.m_addr), 64'h340);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0013;
        cyc();
        chk("t4b_ready", 64'(bus.if_ready), 64'h1);
        chk("t4b_rdata", 64'(bus.if_rdata), 64'h13);
        bus.if_req = 1'b0; bus.m_ack = 1'b0;
        cyc();

        // 5: no ack, watchdog aborts after 8 busy cycles
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0400;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("t5_m_req_%0d", i),  64'(bus.m_req),   64'h1);
            chk($sformatf("t5_no_err_%0d", i), 64'(bus.bus_err), 64'h0);
        end
        cyc();
        chk("t5_m_req_off", 64'(bus.m_req),   64'h0);
        chk("t5_bus_err",   64'(bus.bus_err), 64'h1);
        chk("t5_d_ready",   64'(bus.d_ready), 64'h1);
        chk("t5_d_rdata",   64'(bus.d_rdata), 64'h0);
        bus.d_rd = 1'b0;
        cyc();
        chk("t5_err_pulse", 64'(bus.bus_err), 64'h0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
        cyc();
        bus.m_ack = 1'b0;
        cyc();
        chk("t5_idle_ack_d",  64'(bus.d_ready),  64'h0);
        chk("t5_idle_ack_if", 64'(bus.if_ready), 64'h0);
        chk("t5_idle_m_req",  64'(bus.m_req),    64'h0);

        // 6: reset asserted mid-transaction
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0500;
        cyc();
        chk("t6_m_req", 64'(bus.m_req), 64'h1);
        #2;
        rst = 1'b0;
        bus.d_rd = 1'b0;
        #1;
        chk("t6_async_m_req", 64'(bus.m_req),  64'h0);
        chk("t6_async_addr",  64'(bus.m_addr), 64'h0);
        cyc();
        rst = 1'b1;
        bus.m_ack = 1'b1; bus.m_rdata = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t6_no_ready_%0d", i), 64'(bus.d_ready), 64'h0);
            chk($sformatf("t6_no_req_%0d", i),   64'(bus.m_req),   64'h0);
        end
        bus.m_ack = 1'b0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0600;
        cyc();
        chk("t6_new_addr", 64'(bus.m_addr), 64'h600);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
        cyc();
        chk("t6_new_ready", 64'(bus.d_ready), 64'h1);
        chk("t6_new_rdata", 64'(bus.d_rdata), 64'hCAFE_F00D);
        bus.d_rd = 1'b0; bus.m_ack = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
